// File: rtl/lsu_mem_access.sv
// -----------------------------------------------------------------------------
// lsu_mem_access
// Load/store access unit of the multi-cycle RV32I core. It accepts one decoded
// memory instruction at a time, runs the request/response handshake with data
// memory, builds byte strobes and replicated store data, and aligns and extends
// load data for writeback. Misaligned or illegally encoded accesses finish with
// misalign_err set and never raise a memory request.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin an access (sampled only while idle)
//   mem_read/mem_write  decoder load/store flags
//   mem_src             decoder one-hot {sh,sb,sw,lhu,lh,lbu,lb,lw} (bit7..bit0)
//   addr, store_data    effective address and rs2 value
//   Address             word-aligned request address
//   MemWrite, MemRead   request valids, held until Mem_Req_Ready
//   Write_data/strb     lane-replicated store data and byte enables
//   Mem_Req_Ready       memory accepts the pending request
//   Read_data(_Valid)   read response; Read_data_Ready while waiting for it
//   load_result         aligned/extended load value, held until the next load
//   done, misalign_err  one-cycle completion pulse and its error flag
//   busy                access in progress
// -----------------------------------------------------------------------------
module lsu_mem_access #(
    parameter int ADDR_W      = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [7:0]        mem_src,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [ADDR_W-1:0] Address,
    output logic              MemWrite,
    output logic [31:0]       Write_data,
    output logic [3:0]        Write_strb,
    output logic              MemRead,
    input  logic              Mem_Req_Ready,
    input  logic [31:0]       Read_data,
    input  logic              Read_data_Valid,
    output logic              Read_data_Ready,
    output logic [31:0]       load_result,
    output logic              done,
    output logic              misalign_err,
    output logic              busy
);

    // Bit positions inside the one-hot mem_src vector.
    localparam int B_LW  = 0;
    localparam int B_LB  = 1;
    localparam int B_LBU = 2;
    localparam int B_LH  = 3;
    localparam int B_LHU = 4;
    localparam int B_SW  = 5;
    localparam int B_SB  = 6;
    localparam int B_SH  = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  off_r;     // byte offset used for lane selection
    logic [7:0]  src_r;     // latched access type
    logic        err_r;     // access rejected, reported with done

    logic        onehot_s;
    logic        load_type_s;
    logic        store_type_s;
    logic        legal_s;
    logic        half_s;
    logic        word_s;
    logic        misalign_s;
    logic [1:0]  eff_off_s;
    logic [3:0]  strb_s;
    logic [31:0] wdata_s;

    function automatic logic is_onehot8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return (cnt == 4'd1);
    endfunction

    // Select the addressed byte/halfword of a read word and extend it.
    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [7:0]  src,
                                               input logic [1:0]  off);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = 8'(word >> {off, 3'b000});
        half_v = 16'(word >> {off[1], 4'b0000});
        if (src[B_LB]) begin
            res = {{24{byte_v[7]}}, byte_v};
        end else if (src[B_LBU]) begin
            res = {24'd0, byte_v};
        end else if (src[B_LH]) begin
            res = {{16{half_v[15]}}, half_v};
        end else if (src[B_LHU]) begin
            res = {16'd0, half_v};
        end else begin
            res = word;
        end
        return res;
    endfunction

    // Classify the incoming decoder request and prepare store lanes.
    always_comb begin
        onehot_s     = is_onehot8(mem_src);
        load_type_s  = |mem_src[B_LHU:B_LW];
        store_type_s = |mem_src[B_SH:B_SW];
        legal_s      = onehot_s &&
                       ((mem_read && !mem_write && load_type_s) ||
                        (mem_write && !mem_read && store_type_s));
        half_s       = mem_src[B_SH] | mem_src[B_LH] | mem_src[B_LHU];
        word_s       = mem_src[B_SW] | mem_src[B_LW];
        misalign_s   = ALIGN_CHECK &&
                       ((half_s && addr[0]) || (word_s && (addr[1:0] != 2'b00)));
        // With the check disabled the offset is rounded down to the access size.
        if (word_s) begin
            eff_off_s = 2'b00;
        end else if (half_s) begin
            eff_off_s = {addr[1], 1'b0};
        end else begin
            eff_off_s = addr[1:0];
        end
        if (mem_src[B_SW]) begin
            strb_s  = 4'b1111;
            wdata_s = store_data;
        end else if (mem_src[B_SH]) begin
            strb_s  = eff_off_s[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{store_data[15:0]}};
        end else if (mem_src[B_SB]) begin
            strb_s  = 4'b0001 << eff_off_s;
            wdata_s = {4{store_data[7:0]}};
        end else begin
            strb_s  = 4'b0000;
            wdata_s = 32'd0;
        end
    end

    // Access FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            off_r           <= 2'b00;
            src_r           <= 8'd0;
            err_r           <= 1'b0;
            Address         <= '0;
            MemWrite        <= 1'b0;
            Write_data      <= 32'd0;
            Write_strb      <= 4'd0;
            MemRead         <= 1'b0;
            Read_data_Ready <= 1'b0;
            load_result     <= 32'd0;
            done            <= 1'b0;
            misalign_err    <= 1'b0;
            busy            <= 1'b0;
        end else begin
            done         <= 1'b0;
            misalign_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        Address <= {addr[ADDR_W-1:2], 2'b00};
                        off_r   <= eff_off_s;
                        src_r   <= mem_src;
                        busy    <= 1'b1;
                        if (!legal_s || misalign_s) begin
                            err_r   <= 1'b1;
                            state_r <= ST_FIN;
                        end else if (mem_write) begin
                            err_r      <= 1'b0;
                            MemWrite   <= 1'b1;
                            Write_data <= wdata_s;
                            Write_strb <= strb_s;
                            state_r    <= ST_WR_REQ;
                        end else begin
                            err_r   <= 1'b0;
                            MemRead <= 1'b1;
                            state_r <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (Mem_Req_Ready) begin
                        MemWrite <= 1'b0;
                        state_r  <= ST_FIN;
                    end
                end
                ST_RD_REQ: begin
                    if (Mem_Req_Ready) begin
                        MemRead         <= 1'b0;
                        Read_data_Ready <= 1'b1;
                        state_r         <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (Read_data_Valid) begin
                        load_result     <= align_load(Read_data, src_r, off_r);
                        Read_data_Ready <= 1'b0;
                        state_r         <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done         <= 1'b1;
                    misalign_err <= err_r;
                    err_r        <= 1'b0;
                    busy         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    MemWrite        <= 1'b0;
                    MemRead         <= 1'b0;
                    Read_data_Ready <= 1'b0;
                    busy            <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_access
// Drives two copies of lsu_mem_access (alignment check on / off) with the same
// directed and randomized accesses and compares them against a behavioural
// model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_lsu_mem_access;

    localparam logic [7:0] SRC_LW  = 8'h01;
    localparam logic [7:0] SRC_LB  = 8'h02;
    localparam logic [7:0] SRC_LBU = 8'h04;
    localparam logic [7:0] SRC_LH  = 8'h08;
    localparam logic [7:0] SRC_LHU = 8'h10;
    localparam logic [7:0] SRC_SW  = 8'h20;
    localparam logic [7:0] SRC_SB  = 8'h40;
    localparam logic [7:0] SRC_SH  = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mem_read, mem_write;
    logic [7:0]  mem_src;
    logic [31:0] addr, store_data;
    logic        mem_req_ready, read_data_valid;
    logic [31:0] read_data;

    logic [1:0][31:0] address_w, write_data_w, load_result_w;
    logic [1:0][3:0]  write_strb_w;
    logic [1:0]       mem_write_w, mem_read_w, rd_ready_w, done_w, err_w, busy_w;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] prev_ld [2];

    always #5 clk = ~clk;

    lsu_mem_access #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .mem_src(mem_src), .addr(addr), .store_data(store_data),
        .Address(address_w[0]), .MemWrite(mem_write_w[0]), .Write_data(write_data_w[0]),
        .Write_strb(write_strb_w[0]), .MemRead(mem_read_w[0]), .Mem_Req_Ready(mem_req_ready),
        .Read_data(read_data), .Read_data_Valid(read_data_valid), .Read_data_Ready(rd_ready_w[0]),
        .load_result(load_result_w[0]), .done(done_w[0]), .misalign_err(err_w[0]), .busy(busy_w[0])
    );

    lsu_mem_access #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) u_dut_nc (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .mem_src(mem_src), .addr(addr), .store_data(store_data),
        .Address(address_w[1]), .MemWrite(mem_write_w[1]), .Write_data(write_data_w[1]),
        .Write_strb(write_strb_w[1]), .MemRead(mem_read_w[1]), .Mem_Req_Ready(mem_req_ready),
        .Read_data(read_data), .Read_data_Valid(read_data_valid), .Read_data_Ready(rd_ready_w[1]),
        .load_result(load_result_w[1]), .done(done_w[1]), .misalign_err(err_w[1]), .busy(busy_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what one access should do, from the load/store rules alone.
    function automatic void ref_access(input bit rd, input bit wr, input logic [7:0] src,
                                       input logic [31:0] a, input logic [31:0] sd,
                                       input logic [31:0] word, input bit ac,
                                       output bit err, output bit is_st, output bit is_ld,
                                       output logic [3:0] strb, output logic [31:0] wdata,
                                       output logic [31:0] ld);
        int     size;
        int     off;
        bit     sgn;
        bit     st_type;
        bit     legal;
        longint mask;
        longint v;
        size = 1; sgn = 1'b0; st_type = 1'b0; legal = 1'b1;
        case (src)
            SRC_LW:  size = 4;
            SRC_LB:  begin size = 1; sgn = 1'b1; end
            SRC_LBU: size = 1;
            SRC_LH:  begin size = 2; sgn = 1'b1; end
            SRC_LHU: size = 2;
            SRC_SW:  begin size = 4; st_type = 1'b1; end
            SRC_SB:  begin size = 1; st_type = 1'b1; end
            SRC_SH:  begin size = 2; st_type = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (rd == wr) legal = 1'b0;
        if (wr != st_type) legal = 1'b0;
        off = int'(a % 32'd4);
        if (!ac) off = off - (off % size);
        err   = !legal || ((off % size) != 0);
        is_st = !err && st_type;
        is_ld = !err && !st_type;
        strb  = 4'(((1 << size) - 1) << off);
        if (size == 1)      wdata = (sd & 32'hFF) * 32'h01010101;
        else if (size == 2) wdata = (sd & 32'hFFFF) * 32'h00010001;
        else                wdata = sd;
        mask = (64'd1 << (8 * size)) - 64'd1;
        v = (longint'(word) >> (8 * off)) & mask;
        if (sgn && (v > (mask >> 1))) v = v - (mask + 64'd1);
        ld = v[31:0];
    endfunction

    // One access on both instances; rdelay < 0 means random handshakes.
    task automatic run_access(input bit rd, input bit wr, input logic [7:0] src,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] word, input int rdelay, input int vdelay,
                              input string tag);
        bit          err [2];
        bit          is_st [2];
        bit          is_ld [2];
        logic [3:0]  strb [2];
        logic [31:0] wdata [2];
        logic [31:0] ld [2];
        int          n_done [2];
        int          n_wr [2];
        int          n_rd [2];
        int          n_req_cyc [2];
        int          lat [2];
        int          last_k;
        int          exp_lat;
        bit          rdy, vld;
        for (int i = 0; i < 2; i++) begin
            ref_access(rd, wr, src, a, sd, word, (i == 0), err[i], is_st[i], is_ld[i],
                       strb[i], wdata[i], ld[i]);
            n_done[i] = 0; n_wr[i] = 0; n_rd[i] = 0; n_req_cyc[i] = 0; lat[i] = -1;
        end
        mem_read = rd; mem_write = wr; mem_src = src; addr = a; store_data = sd;
        start = 1'b1;
        mem_req_ready = 1'($urandom); read_data_valid = 1'($urandom); read_data = $urandom;
        last_k = 200;
        for (int k = 0; k < last_k; k++) begin
            @(negedge clk);
            start = 1'b0;
            mem_read = 1'($urandom); mem_write = 1'($urandom); mem_src = 8'($urandom);
            addr = $urandom; store_data = $urandom;
            if (rdelay < 0) begin
                rdy = 1'($urandom); vld = 1'($urandom);
            end else begin
                rdy = (k + 1 > rdelay); vld = (k + 1 > rdelay + 1 + vdelay);
            end
            mem_req_ready = rdy; read_data_valid = vld;
            read_data = vld ? word : $urandom;
            for (int i = 0; i < 2; i++) begin
                if (mem_write_w[i] || mem_read_w[i]) begin
                    n_req_cyc[i]++;
                    check_eq($sformatf("%s_addr_held%0d", tag, i), address_w[i], {a[31:2], 2'b00});
                end
                if (mem_write_w[i] && rdy) begin
                    n_wr[i]++;
                    check_eq($sformatf("%s_strb%0d", tag, i), 32'(write_strb_w[i]), 32'(strb[i]));
                    check_eq($sformatf("%s_wdata%0d", tag, i), write_data_w[i], wdata[i]);
                end
                if (mem_read_w[i] && rdy) n_rd[i]++;
                if (done_w[i]) begin
                    n_done[i]++;
                    lat[i] = k + 1;
                    check_eq($sformatf("%s_err%0d", tag, i), 32'(err_w[i]), 32'(err[i]));
                end else if (err_w[i]) begin
                    check_eq($sformatf("%s_err_no_done%0d", tag, i), 32'(err_w[i]), 32'd0);
                end
            end
            if (n_done[0] > 0 && n_done[1] > 0 && last_k == 200) last_k = k + 4;
            // A start while both are busy must be ignored.
            start = busy_w[0] & busy_w[1] & 1'($urandom);
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s_done_cnt%0d", tag, i), 32'(n_done[i]), 32'd1);
            check_eq($sformatf("%s_wr_cnt%0d", tag, i), 32'(n_wr[i]), 32'(is_st[i]));
            check_eq($sformatf("%s_rd_cnt%0d", tag, i), 32'(n_rd[i]), 32'(is_ld[i]));
            if (err[i]) check_eq($sformatf("%s_no_req%0d", tag, i), 32'(n_req_cyc[i]), 32'd0);
            if (is_ld[i]) prev_ld[i] = ld[i];
            check_eq($sformatf("%s_load%0d", tag, i), load_result_w[i], prev_ld[i]);
            if (rdelay >= 0) begin
                if (err[i])        exp_lat = 2;
                else if (is_st[i]) exp_lat = 3 + rdelay;
                else               exp_lat = 4 + rdelay + vdelay;
                check_eq($sformatf("%s_latency%0d", tag, i), 32'(lat[i]), 32'(exp_lat));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_src = 8'd0;
        addr = 32'd0; store_data = 32'd0; mem_req_ready = 1'b0; read_data_valid = 1'b0;
        read_data = 32'd0;
        prev_ld[0] = 32'd0; prev_ld[1] = 32'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_address%0d", i), address_w[i], 32'd0);
            check_eq($sformatf("rst_wdata%0d", i), write_data_w[i], 32'd0);
            check_eq($sformatf("rst_strb%0d", i), 32'(write_strb_w[i]), 32'd0);
            check_eq($sformatf("rst_load%0d", i), load_result_w[i], 32'd0);
            check_eq($sformatf("rst_flags%0d", i),
                     32'({mem_write_w[i], mem_read_w[i], rd_ready_w[i], done_w[i], err_w[i], busy_w[i]}),
                     32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Stores with ready tied high.
        run_access(1'b0, 1'b1, SRC_SW, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0, "sw");
        check_eq("sw_address", address_w[0], 32'h100);
        run_access(1'b0, 1'b1, SRC_SB, 32'h103, 32'h000000A5, 32'd0, 0, 0, "sb");
        check_eq("sb_strb", 32'(write_strb_w[0]), 32'h8);
        check_eq("sb_wdata", write_data_w[0], 32'hA5A5A5A5);
        run_access(1'b0, 1'b1, SRC_SH, 32'h102, 32'h1234BEEF, 32'd0, 0, 0, "sh");
        check_eq("sh_strb", 32'(write_strb_w[0]), 32'hC);

        // Loads of one word with every extension rule.
        run_access(1'b1, 1'b0, SRC_LB, 32'h200, 32'd0, 32'h80F17F82, 0, 0, "lb");
        check_eq("lb_value", load_result_w[0], 32'hFFFFFF82);
        run_access(1'b1, 1'b0, SRC_LBU, 32'h203, 32'd0, 32'h80F17F82, 0, 0, "lbu");
        check_eq("lbu_value", load_result_w[0], 32'h00000080);
        run_access(1'b1, 1'b0, SRC_LH, 32'h202, 32'd0, 32'h80F17F82, 0, 0, "lh");
        check_eq("lh_value", load_result_w[0], 32'hFFFF80F1);
        run_access(1'b1, 1'b0, SRC_LHU, 32'h200, 32'd0, 32'h80F17F82, 0, 0, "lhu");
        check_eq("lhu_value", load_result_w[0], 32'h00007F82);
        run_access(1'b1, 1'b0, SRC_LW, 32'h200, 32'd0, 32'h80F17F82, 0, 0, "lw");
        check_eq("lw_value", load_result_w[0], 32'h80F17F82);

        // Misaligned lw: flagged with the check on, rounded down with it off.
        run_access(1'b1, 1'b0, SRC_LW, 32'h102, 32'd0, 32'h13579BDF, 0, 0, "lw_mis");
        check_eq("lw_mis_nc_address", address_w[1], 32'h100);
        check_eq("lw_mis_nc_value", load_result_w[1], 32'h13579BDF);
        check_eq("lw_mis_held", load_result_w[0], 32'h80F17F82);

        // Back-pressure: request held 5 cycles, read data 3 cycles late.
        run_access(1'b1, 1'b0, SRC_LW, 32'h300, 32'd0, 32'h2468ACE0, 5, 3, "lw_slow");
        run_access(1'b0, 1'b1, SRC_SB, 32'h301, 32'h0000005A, 32'd0, 5, 0, "sb_slow");

        // Randomized mix of legal, misaligned and illegal accesses.
        for (int t = 0; t < 80; t++) begin
            logic [7:0] src;
            bit         rd_b, wr_b;
            int         sel;
            sel  = $urandom_range(0, 7);
            src  = 8'h01 << sel;
            rd_b = (sel < 5);
            wr_b = !rd_b;
            if ($urandom_range(0, 9) == 0) begin
                src = 8'($urandom); rd_b = 1'($urandom); wr_b = 1'($urandom);
            end
            run_access(rd_b, wr_b, src, $urandom, $urandom, $urandom,
                       ($urandom_range(0, 3) == 0) ? 0 : -1, $urandom_range(0, 2), "rnd");
        end

        // Reset while waiting for read data.
        mem_read = 1'b1; mem_write = 1'b0; mem_src = SRC_LW; addr = 32'h400;
        store_data = 32'd0; start = 1'b1; mem_req_ready = 1'b1; read_data_valid = 1'b0;
        read_data = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_rd_ready", 32'(rd_ready_w[0]), 32'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("mid_rst_flags%0d", i),
                     32'({mem_write_w[i], mem_read_w[i], rd_ready_w[i], done_w[i], busy_w[i]}), 32'd0);
            check_eq($sformatf("mid_rst_load%0d", i), load_result_w[i], 32'd0);
            check_eq($sformatf("mid_rst_address%0d", i), address_w[i], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        read_data_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("post_rst_no_done", 32'(done_w), 32'd0);
        end
        prev_ld[0] = 32'd0; prev_ld[1] = 32'd0;
        run_access(1'b1, 1'b0, SRC_LW, 32'h404, 32'd0, 32'hCAFEF00D, 0, 0, "lw_after_rst");
        check_eq("lw_after_rst_value", load_result_w[0], 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
